// File: rtl/time_keeper_pkg.sv
// Shared definitions for the time_keeper clock block: set-mode state
// encoding, BCD field limits and common widths.
package time_keeper_pkg;

  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned BCD_W   = 2 * DIGIT_W;
  localparam int unsigned SEL_W   = 2;

  // Encoding is visible on set_sel, so the values are fixed.
  typedef enum logic [SEL_W-1:0] {
    ST_RUN     = 2'b00,
    ST_SET_HR  = 2'b01,
    ST_SET_MIN = 2'b10
  } state_t;

  // Two-digit BCD limits, written as {hi, lo} nibbles.
  localparam logic [BCD_W-1:0] SEC_MAX    = 8'h59;
  localparam logic [BCD_W-1:0] MIN_MAX    = 8'h59;
  localparam logic [BCD_W-1:0] HR24_MAX   = 8'h23;
  localparam logic [BCD_W-1:0] HR12_MAX   = 8'h12;
  localparam logic [BCD_W-1:0] HR12_MIN   = 8'h01;
  localparam logic [BCD_W-1:0] BCD_ZERO   = 8'h00;
  // Hour value that precedes 12 o'clock; stepping past it flips am/pm.
  localparam logic [BCD_W-1:0] HR12_PM_EDGE = 8'h11;

endpackage

// File: rtl/time_keeper_if.sv
// Button/tick inputs and BCD time outputs of time_keeper.
// master: the driver of tick_in/mode_btn/inc_btn (upstream logic or bench).
// slave : time_keeper itself, which returns digits, pm, set_sel, day_carry.
interface time_keeper_if;
  import time_keeper_pkg::*;

  logic               tick_in;
  logic               mode_btn;
  logic               inc_btn;
  logic [DIGIT_W-1:0] sec_lo;
  logic [DIGIT_W-1:0] sec_hi;
  logic [DIGIT_W-1:0] min_lo;
  logic [DIGIT_W-1:0] min_hi;
  logic [DIGIT_W-1:0] hr_lo;
  logic [DIGIT_W-1:0] hr_hi;
  logic               pm;
  logic [SEL_W-1:0]   set_sel;
  logic               day_carry;

  modport master (
    output tick_in, mode_btn, inc_btn,
    input  sec_lo, sec_hi, min_lo, min_hi, hr_lo, hr_hi, pm, set_sel, day_carry
  );

  modport slave (
    input  tick_in, mode_btn, inc_btn,
    output sec_lo, sec_hi, min_lo, min_hi, hr_lo, hr_hi, pm, set_sel, day_carry
  );
endinterface

// File: rtl/time_keeper_bcd_pair_cnt.sv
// bcd_pair_cnt: two-digit BCD counter. Counts up on inc, jumps to WRAP_VAL
// after MAX_VAL, and loads RST_VAL on reset or clr.
// Ports: clk, rst_n (sync, active-low), clr, inc, lo/hi digits (registered),
//        wrap_c (combinational: the next inc will wrap).
module bcd_pair_cnt
  import time_keeper_pkg::*;
#(
  parameter logic [BCD_W-1:0] MAX_VAL  = SEC_MAX,
  parameter logic [BCD_W-1:0] WRAP_VAL = BCD_ZERO,
  parameter logic [BCD_W-1:0] RST_VAL  = BCD_ZERO
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               inc,
  output logic [DIGIT_W-1:0] lo,
  output logic [DIGIT_W-1:0] hi,
  output logic               wrap_c
);

  assign wrap_c = ({hi, lo} == MAX_VAL);

  // Digit update; lo rolls 9->0 with a carry into hi.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      {hi, lo} <= RST_VAL;
    end else if (inc) begin
      if (wrap_c) begin
        {hi, lo} <= WRAP_VAL;
      end else if (lo == DIGIT_W'(9)) begin
        lo <= '0;
        hi <= DIGIT_W'(hi + DIGIT_W'(1));
      end else begin
        lo <= DIGIT_W'(lo + DIGIT_W'(1));
      end
    end
  end

endmodule

// File: rtl/time_keeper.sv
// time_keeper: BCD time-of-day clock with a RUN / SET_HR / SET_MIN set mode.
// Ports: clk, rst_n (sync, active-low), bus (time_keeper_if.slave) carrying
//        tick_in, mode_btn, inc_btn in and the BCD digits, pm, set_sel,
//        day_carry out. TWELVE_HR selects 12-hour display with pm flag.
module time_keeper
  import time_keeper_pkg::*;
#(
  parameter bit TWELVE_HR = 1'b0
) (
  input  logic          clk,
  input  logic          rst_n,
  time_keeper_if.slave  bus
);

  localparam logic [BCD_W-1:0] HR_MAX  = TWELVE_HR ? HR12_MAX : HR24_MAX;
  localparam logic [BCD_W-1:0] HR_WRAP = TWELVE_HR ? HR12_MIN : BCD_ZERO;
  localparam logic [BCD_W-1:0] HR_RST  = TWELVE_HR ? HR12_MAX : BCD_ZERO;

  state_t             state;
  logic               pm;
  logic               day_carry;
  logic [DIGIT_W-1:0] sec_lo, sec_hi, min_lo, min_hi, hr_lo, hr_hi;
  logic               sec_wrap_c, min_wrap_c, hr_wrap_c;
  logic               run_tick_c, set_hr_inc_c, set_min_inc_c;
  logic               min_inc_c, hr_inc_c, sec_clr_c;
  logic               hr_pm_edge_c, midnight_c;

  // In a SET state mode_btn has priority over inc_btn.
  assign run_tick_c    = (state == ST_RUN) && bus.tick_in;
  assign set_hr_inc_c  = (state == ST_SET_HR) && bus.inc_btn && !bus.mode_btn;
  assign set_min_inc_c = (state == ST_SET_MIN) && bus.inc_btn && !bus.mode_btn;

  // Ripple carries only while running; set-mode increments never carry.
  assign min_inc_c = (run_tick_c && sec_wrap_c) || set_min_inc_c;
  assign hr_inc_c  = (run_tick_c && sec_wrap_c && min_wrap_c) || set_hr_inc_c;
  assign sec_clr_c = (state == ST_SET_MIN) && bus.mode_btn;

  assign hr_pm_edge_c = ({hr_hi, hr_lo} == HR12_PM_EDGE);

  // Midnight in 12-hour mode is 11:59:59 pm -> 12:00:00 am.
  assign midnight_c = run_tick_c && sec_wrap_c && min_wrap_c &&
                      (TWELVE_HR ? (hr_pm_edge_c && pm) : hr_wrap_c);

  bcd_pair_cnt #(.MAX_VAL(SEC_MAX), .WRAP_VAL(BCD_ZERO), .RST_VAL(BCD_ZERO)) u_sec (
    .clk(clk), .rst_n(rst_n), .clr(sec_clr_c), .inc(run_tick_c),
    .lo(sec_lo), .hi(sec_hi), .wrap_c(sec_wrap_c)
  );

  bcd_pair_cnt #(.MAX_VAL(MIN_MAX), .WRAP_VAL(BCD_ZERO), .RST_VAL(BCD_ZERO)) u_min (
    .clk(clk), .rst_n(rst_n), .clr(1'b0), .inc(min_inc_c),
    .lo(min_lo), .hi(min_hi), .wrap_c(min_wrap_c)
  );

  bcd_pair_cnt #(.MAX_VAL(HR_MAX), .WRAP_VAL(HR_WRAP), .RST_VAL(HR_RST)) u_hr (
    .clk(clk), .rst_n(rst_n), .clr(1'b0), .inc(hr_inc_c),
    .lo(hr_lo), .hi(hr_hi), .wrap_c(hr_wrap_c)
  );

  // Set-mode FSM, advanced only by mode_btn.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_RUN;
    end else if (bus.mode_btn) begin
      case (state)
        ST_RUN:    state <= ST_SET_HR;
        ST_SET_HR: state <= ST_SET_MIN;
        default:   state <= ST_RUN;
      endcase
    end
  end

  // am/pm flips whenever the hour steps 11 -> 12, by tick carry or by setting.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pm        <= 1'b0;
      day_carry <= 1'b0;
    end else begin
      day_carry <= midnight_c;
      if (TWELVE_HR && hr_inc_c && hr_pm_edge_c) begin
        pm <= ~pm;
      end
    end
  end

  assign bus.sec_lo    = sec_lo;
  assign bus.sec_hi    = sec_hi;
  assign bus.min_lo    = min_lo;
  assign bus.min_hi    = min_hi;
  assign bus.hr_lo     = hr_lo;
  assign bus.hr_hi     = hr_hi;
  assign bus.pm        = pm;
  assign bus.set_sel   = SEL_W'(state);
  assign bus.day_carry = day_carry;

endmodule

// File: tb/tb_time_keeper.sv
// Bench for time_keeper: a 24-hour and a 12-hour instance share one stimulus
// stream. A seconds-of-day model predicts both displays; expected values are
// queued at stimulus time and checked by a monitor after each clock edge.
module tb_time_keeper;

  logic clk = 1'b0;
  logic rst_n;

  time_keeper_if bus0 ();
  time_keeper_if bus1 ();

  time_keeper #(.TWELVE_HR(1'b0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0.slave));
  time_keeper #(.TWELVE_HR(1'b1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] h24;
    logic [7:0] h12;
    logic [7:0] mm;
    logic [7:0] ss;
    logic       pm;
    logic       dc;
    logic [1:0] sel;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;

  // Reference model: time as seconds since midnight, plus set-mode index.
  int    t_sec = 0;
  int    mode_st = 0;
  bit    dc_m = 1'b0;
  string phase = "init";
  bit    chk_hold = 1'b0;

  function automatic logic [7:0] bcd(int v);
    logic [7:0] r;
    r = {4'(v / 10), 4'(v % 10)};
    return r;
  endfunction

  function automatic exp_t snap();
    exp_t e;
    int   h;
    h     = t_sec / 3600;
    e.h24 = bcd(h);
    e.h12 = bcd((h % 12 == 0) ? 12 : h % 12);
    e.mm  = bcd((t_sec / 60) % 60);
    e.ss  = bcd(t_sec % 60);
    e.pm  = (h >= 12);
    e.dc  = dc_m;
    e.sel = 2'(mode_st);
    return e;
  endfunction

  task automatic check(exp_t e, string tag);
    logic [27:0] got0, got1, req0, req1;
    got0 = {bus0.hr_hi, bus0.hr_lo, bus0.min_hi, bus0.min_lo, bus0.sec_hi, bus0.sec_lo,
            bus0.pm, bus0.day_carry, bus0.set_sel};
    got1 = {bus1.hr_hi, bus1.hr_lo, bus1.min_hi, bus1.min_lo, bus1.sec_hi, bus1.sec_lo,
            bus1.pm, bus1.day_carry, bus1.set_sel};
    req0 = {e.h24, e.mm, e.ss, 1'b0, e.dc, e.sel};
    req1 = {e.h12, e.mm, e.ss, e.pm, e.dc, e.sel};
    n_cmp += 2;
    if (got0 !== req0) begin
      n_bad++;
      $display("FAIL %s 24h: got hhmmss=%h pm=%b dc=%b sel=%b, want hhmmss=%h pm=%b dc=%b sel=%b",
               tag, got0[27:4], got0[3], got0[2], got0[1:0], req0[27:4], req0[3], req0[2], req0[1:0]);
    end
    if (got1 !== req1) begin
      n_bad++;
      $display("FAIL %s 12h: got hhmmss=%h pm=%b dc=%b sel=%b, want hhmmss=%h pm=%b dc=%b sel=%b",
               tag, got1[27:4], got1[3], got1[2], got1[1:0], req1[27:4], req1[3], req1[2], req1[1:0]);
    end
  endtask

  // One clock of stimulus: drive at the falling edge, advance the model,
  // queue what both instances must show after the next rising edge.
  task automatic step(bit tk, bit md, bit ic, bit rs);
    exp_t prev;
    int   m;
    @(negedge clk);
    prev = snap();
    rst_n = rs;
    bus0.tick_in = tk; bus0.mode_btn = md; bus0.inc_btn = ic;
    bus1.tick_in = tk; bus1.mode_btn = md; bus1.inc_btn = ic;
    dc_m = 1'b0;
    if (!rs) begin
      t_sec = 0;
      mode_st = 0;
    end else begin
      case (mode_st)
        0: begin
          if (tk) begin
            t_sec = (t_sec + 1) % 86400;
            dc_m = (t_sec == 0);
          end
          if (md) mode_st = 1;
        end
        1: begin
          if (md) mode_st = 2;
          else if (ic) t_sec = (t_sec + 3600) % 86400;
        end
        default: begin
          if (md) begin
            mode_st = 0;
            t_sec = t_sec - (t_sec % 60);
          end else if (ic) begin
            m = (t_sec / 60) % 60;
            t_sec = t_sec + (((m + 1) % 60) - m) * 60;
          end
        end
      endcase
    end
    exp_q.push_back(snap());
    name_q.push_back(phase);
    // Reset is synchronous: outputs must hold until the edge.
    if (!rs && chk_hold) begin
      #1;
      check(prev, "rst_hold_before_edge");
    end
  endtask

  // Reset, then reach h24:mm:ss in RUN through the set mode and ticks.
  task automatic preset(int h, int m, int s);
    step(0, 0, 0, 0);
    step(0, 1, 0, 1);
    repeat (h) step(0, 0, 1, 1);
    step(0, 1, 0, 1);
    repeat (m) step(0, 0, 1, 1);
    step(0, 1, 0, 1);
    repeat (s) step(1, 0, 0, 1);
  endtask

  // Monitor: compare after every rising edge that has a queued expectation.
  exp_t  mon_e;
  string mon_n;
  always @(posedge clk) begin
    #1;
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      mon_n = name_q.pop_front();
      check(mon_e, mon_n);
    end
  end

  initial begin
    rst_n = 1'b0;
    bus0.tick_in = 1'b0; bus0.mode_btn = 1'b0; bus0.inc_btn = 1'b0;
    bus1.tick_in = 1'b0; bus1.mode_btn = 1'b0; bus1.inc_btn = 1'b0;

    phase = "reset";
    step(0, 0, 0, 0);
    step(1, 1, 1, 0);
    step(0, 0, 1, 1);

    phase = "preload_235958";
    preset(23, 59, 58);
    phase = "midnight_24h";
    step(1, 0, 0, 1);
    step(0, 0, 0, 1);
    step(1, 0, 0, 1);
    step(0, 0, 0, 1);
    step(1, 0, 0, 1);

    phase = "preload_115959";
    preset(11, 59, 59);
    phase = "noon_12h";
    step(1, 0, 0, 1);
    step(0, 0, 0, 1);
    phase = "preload_125959";
    step(0, 1, 0, 1);
    step(0, 1, 0, 1);
    repeat (59) step(0, 0, 1, 1);
    step(0, 1, 0, 1);
    repeat (59) step(1, 0, 0, 1);
    phase = "one_pm";
    step(1, 0, 0, 1);
    step(0, 0, 0, 1);

    phase = "preload_102030";
    preset(10, 20, 30);
    phase = "set_hr";
    step(0, 1, 0, 1);
    repeat (5) begin
      step(0, 0, 1, 1);
      step(1, 0, 1, 1);
      step(0, 0, 1, 1);
      step(1, 0, 0, 1);
    end
    phase = "set_min";
    step(0, 1, 1, 1);
    repeat (45) step(0, 0, 1, 1);
    phase = "set_exit";
    step(0, 1, 0, 1);
    step(1, 0, 1, 1);

    phase = "preload_000005";
    preset(0, 0, 5);
    phase = "mode_and_tick";
    step(1, 1, 0, 1);
    step(1, 0, 0, 1);

    phase = "preload_0733_setmin";
    step(0, 0, 0, 0);
    step(0, 1, 0, 1);
    repeat (7) step(0, 0, 1, 1);
    step(0, 1, 0, 1);
    repeat (33) step(0, 0, 1, 1);
    phase = "reset_in_set_min";
    chk_hold = 1'b1;
    step(1, 1, 1, 0);
    chk_hold = 1'b0;
    step(0, 0, 0, 1);

    phase = "random";
    for (int i = 0; i < 4000; i++) begin
      step($urandom_range(0, 2) != 0,
           $urandom_range(0, 29) == 0,
           $urandom_range(0, 2) == 0,
           $urandom_range(0, 799) != 0);
    end

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/time_keeper.md
TIME_KEEPER -- requirements
Module: time_keeper

Interface
REQ-001 Parameter TWELVE_HR, default 0, selects the hour format: 0 = 24-hour (00..23), 1 = 12-hour (01..12 plus pm flag).
REQ-002 clk  input  1  system clock; every flop in the block SHALL be clocked on its rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 tick_in  input  1  one-cycle "one second elapsed" pulse from the upstream decade-counter cascade carry.
REQ-005 mode_btn  input  1  one-cycle debounced pulse that advances the set-mode FSM.
REQ-006 inc_btn  input  1  one-cycle debounced pulse that increments the field being set.
REQ-007 sec_lo, sec_hi, min_lo, min_hi, hr_lo, hr_hi  output  4 each  BCD time digits, registered.
REQ-008 pm  output  1  afternoon flag, registered; tied 0 when TWELVE_HR=0.
REQ-009 set_sel  output  2  FSM state indicator: 00 RUN, 01 SET_HR, 10 SET_MIN.
REQ-010 day_carry  output  1  one-cycle pulse at midnight rollover, registered.

Function
REQ-011 FSM states SHALL be RUN, SET_HR and SET_MIN; mode_btn moves RUN->SET_HR->SET_MIN->RUN, and no other transitions exist.
REQ-012 In RUN, tick_in SHALL advance the time by one second, with the new value visible on the outputs in the cycle after tick_in is sampled (latency 1).
REQ-013 Seconds and minutes SHALL wrap 59->00 and carry into the next field in the same update.
REQ-014 With TWELVE_HR=0, the hour field SHALL wrap 23->00.
REQ-015 With TWELVE_HR=1, the hour field SHALL wrap 12->01, and pm SHALL toggle on the 11:59:59->12:00:00 transition.
REQ-016 day_carry SHALL pulse for exactly one cycle, aligned with the outputs showing midnight.
REQ-016a Midnight is 00:00:00 when TWELVE_HR=0, and 12:00:00 with pm=0 when TWELVE_HR=1.
REQ-017 In SET_HR and SET_MIN, tick_in SHALL be discarded and the time held frozen.
REQ-018 In SET_HR, inc_btn SHALL increment the hours only, with the same wrap as REQ-014/015.
REQ-018a In SET_HR, minutes SHALL NOT change, and day_carry SHALL NOT pulse.
REQ-018b In SET_HR with TWELVE_HR=1, pm SHALL toggle on the 11->12 increment.
REQ-019 In SET_MIN, inc_btn SHALL increment the minutes only, wrapping 59->00 with no carry into hours.
REQ-020 On the SET_MIN->RUN transition, the seconds SHALL be cleared to 00.
REQ-021 In RUN, inc_btn SHALL be ignored.
REQ-022 If mode_btn and tick_in are both asserted in RUN, the time SHALL advance and the state SHALL move to SET_HR in the same cycle.
REQ-023 If mode_btn and inc_btn are both asserted in a SET state, mode_btn SHALL win and inc_btn SHALL be ignored.
REQ-024 Every BCD digit SHALL stay within 0..9 at all times, and no illegal time value SHALL ever appear on the outputs.

Reset
REQ-025 While rst_n=0 at a clk edge, the state SHALL go to RUN.
REQ-025a The same reset SHALL set seconds=00, minutes=00, pm=0 and day_carry=0.
REQ-025b The same reset SHALL set hours=00 when TWELVE_HR=0, and hours=12 when TWELVE_HR=1.
REQ-026 Reset SHALL override any simultaneous tick_in, mode_btn or inc_btn, including mid-set.
REQ-027 Reset SHALL take effect on the first clk edge; no asynchronous path to any flop SHALL exist.

Structure
REQ-028 A shared package SHALL hold the FSM state encoding.
REQ-028a The same package SHALL hold the BCD limit constants: 59 for seconds/minutes, 23 for 24-hour hours, 12 and 01 for 12-hour hours.
REQ-029 One sub-module, bcd_pair_cnt, SHALL be instantiated per field.
REQ-029a bcd_pair_cnt is a two-digit BCD counter with inc enable, a parameterised max value and wrap value, and a combinational wrap flag.
REQ-029b Hour, minute and second chaining and the FSM SHALL live in time_keeper.

Verification
REQ-030 Bench SHALL cover, with TWELVE_HR=0: preload 23:59:58, two tick_in pulses -> 23:59:59, then 00:00:00, with day_carry=1 for one cycle on the second update only.
REQ-031 Bench SHALL cover, with TWELVE_HR=1: preload 11:59:59 pm=0, one tick_in -> 12:00:00 pm=1; preload 12:59:59, one tick_in -> 01:00:00 with pm unchanged.
REQ-032 Bench SHALL cover: at 10:20:30 enter SET_HR, issue 15 inc_btn pulses and 5 tick_in pulses -> 01:20:30 with seconds frozen.
REQ-033 Bench SHALL cover: then in SET_MIN, 45 inc_btn pulses -> minutes 05 with hours still 01; then mode_btn -> RUN at 01:05:00.
REQ-034 Bench SHALL cover: mode_btn and tick_in in the same cycle at 00:00:05 -> 00:00:06 with set_sel=01.
REQ-035 Bench SHALL cover: rst_n low for one cycle while in SET_MIN at 07:33 -> next cycle shows the reset values of REQ-025/025a/025b and set_sel=00, with no change before the clk edge.
